// File: rtl/cordic_approx_pkg.sv
// Shared definitions for the approximate CORDIC arithmetic family.
//   state_t      : divider control states
//   RES_SHIFT    : residual pre-scale applied to both operands
//   ONE_Q8       : unit quotient step in Q8.8
//   Q_SAT_POS/NEG: saturated quotients reported on a domain error
package cordic_approx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ITER,
      ST_DONE
   } state_t;

   localparam int unsigned RES_SHIFT = 6;
   localparam logic [15:0] ONE_Q8    = 16'h0100;
   localparam logic [15:0] Q_SAT_POS = 16'h7FFF;
   localparam logic [15:0] Q_SAT_NEG = 16'h8000;

endpackage

// File: rtl/add16se_2TN.sv
// Approximate 16-bit sign-extended adder with a 17-bit result.
// The two low bits are formed with OR and produce no carry; bits 16:2
// come from an exact add of the sign-extended upper slices.
//   A, B : 16-bit two's-complement operands
//   O    : 17-bit approximate sum
module add16se_2TN (
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [16:0] O
);

   logic [14:0] w_hi;

   assign w_hi = {A[15], A[15:2]} + {B[15], B[15:2]};
   assign O    = {w_hi, A[1:0] | B[1:0]};

endmodule

// File: rtl/cordic_divider_approx_2tn.sv
// Iterative linear-vectoring CORDIC divider, z ~= 256*y/x in Q8.8.
// Residual updates go through one add16se_2TN; the quotient uses an exact adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled in IDLE only
//   y, x       : signed dividend / divisor, captured on accepted start
//   z          : registered signed quotient, held until the next result
//   done       : one-cycle pulse when z/err are valid
//   busy       : high in CHECK and ITER
//   err        : domain error (x==0 or |y|>|x|), loaded with z
module cordic_divider_approx_2tn
   import cordic_approx_pkg::*;
#(
   parameter int unsigned MAX_ITERATIONS = 16,
   parameter int unsigned FRAC_BITS      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  y,
   input  logic [7:0]  x,
   output logic [15:0] z,
   output logic        done,
   output logic        busy,
   output logic        err
);

   state_t r_state;
   state_t w_state_next;

   logic [7:0]  r_x;
   logic [7:0]  r_y;
   logic [15:0] r_r;
   logic [15:0] r_q;
   logic [4:0]  r_iter;
   logic [15:0] r_z;
   logic        r_err;

   logic [8:0]         w_ext_x;
   logic [8:0]         w_ext_y;
   logic [8:0]         w_abs_x;
   logic [8:0]         w_abs_y;
   logic               w_dom_err;
   logic [15:0]        w_sat;
   logic signed [15:0] w_x_scaled;
   logic signed [15:0] w_y_scaled;
   logic signed [15:0] w_step;
   logic [15:0]        w_inc;
   logic               w_d;
   logic [15:0]        w_addend;
   logic [16:0]        w_sum;
   logic               w_unused_msb;
   logic [15:0]        w_q_next;
   logic               w_last;

   // 9-bit magnitudes so that -128 compares correctly
   assign w_ext_x   = {r_x[7], r_x};
   assign w_ext_y   = {r_y[7], r_y};
   assign w_abs_x   = r_x[7] ? (9'd0 - w_ext_x) : w_ext_x;
   assign w_abs_y   = r_y[7] ? (9'd0 - w_ext_y) : w_ext_y;
   assign w_dom_err = (r_x == '0) || (w_abs_y > w_abs_x);
   assign w_sat     = (r_y[7] == r_x[7]) ? Q_SAT_POS : Q_SAT_NEG;

   assign w_x_scaled = 16'(signed'(r_x)) <<< RES_SHIFT;
   assign w_y_scaled = 16'(signed'(r_y)) <<< RES_SHIFT;
   assign w_step     = w_x_scaled >>> r_iter;
   assign w_inc      = (r_iter > 5'(FRAC_BITS)) ? '0 : (ONE_Q8 >> r_iter);

   // Drive r toward zero: subtract when r and x share a sign (r==0 is positive)
   assign w_d      = (r_r[15] == r_x[7]);
   assign w_addend = w_d ? -w_step : w_step;

   add16se_2TN u_add (
      .A (r_r),
      .B (w_addend),
      .O (w_sum)
   );

   // Residual cannot exceed 16 bits for in-domain operands; the carry-out is dropped
   assign w_unused_msb = w_sum[16];
   assign w_q_next     = w_d ? (r_q + w_inc) : (r_q - w_inc);
   assign w_last       = (r_iter == 5'(MAX_ITERATIONS - 1));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = ST_CHECK;
         ST_CHECK: w_state_next = w_dom_err ? ST_DONE : ST_ITER;
         ST_ITER:  if (w_last) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_iter  <= '0;
         r_z     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_x <= x;
                  r_y <= y;
               end
            end
            ST_CHECK: begin
               if (w_dom_err) begin
                  r_z   <= w_sat;
                  r_err <= 1'b1;
               end else begin
                  r_r    <= w_y_scaled;
                  r_q    <= '0;
                  r_iter <= '0;
               end
            end
            ST_ITER: begin
               r_r    <= w_sum[15:0];
               r_q    <= w_q_next;
               r_iter <= r_iter + 5'd1;
               if (w_last) begin
                  r_z   <= w_q_next;
                  r_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign z    = r_z;
   assign err  = r_err;
   assign done = (r_state == ST_DONE);
   assign busy = (r_state == ST_CHECK) || (r_state == ST_ITER);

endmodule

// File: tb/tb_cordic_divider_approx_2tn.sv
// Self-checking bench for cordic_divider_approx_2tn: fixed vectors, random
// operations against a behavioural quotient model, protocol and reset cases.
module tb_cordic_divider_approx_2tn;

   localparam int MAX_IT = 16;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  y;
   logic [7:0]  x;
   logic [15:0] z;
   logic        done;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   cordic_divider_approx_2tn #(
      .MAX_ITERATIONS (MAX_IT),
      .FRAC_BITS      (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .y     (y),
      .x     (x),
      .z     (z),
      .done  (done),
      .busy  (busy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [7:0]  y;
      logic [7:0]  x;
      logic [15:0] z;
      logic        e;
      int          lat;
   } vec_t;

   vec_t tv[8];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Adder behaviour: upper bits add exactly, two low bits are ORed without carry
   function automatic int approx_add(input int a, input int b);
      return (((a >>> 2) + (b >>> 2)) * 4) + ((a | b) & 3);
   endfunction

   function automatic int wrap16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   task automatic model(input logic [7:0] yy, input logic [7:0] xx,
                        output logic [15:0] zz, output logic ee);
      int yi, xi, ay, ax, r, q, step, inc, b;
      bit d;
      yi = int'($signed(yy));
      xi = int'($signed(xx));
      ay = (yi < 0) ? -yi : yi;
      ax = (xi < 0) ? -xi : xi;
      if (xi == 0 || ay > ax) begin
         zz = ((yi < 0) == (xi < 0)) ? 16'h7FFF : 16'h8000;
         ee = 1'b1;
      end else begin
         r = yi * 64;
         q = 0;
         for (int i = 0; i < MAX_IT; i++) begin
            step = (xi * 64) >>> i;
            inc  = (i > 8) ? 0 : (256 >> i);
            d    = ((r >= 0) == (xi >= 0));
            b    = d ? -step : step;
            r    = wrap16(approx_add(r, b));
            q    = d ? q + inc : q - inc;
         end
         zz = q[15:0];
         ee = 1'b0;
      end
   endtask

   // Starts an operation from IDLE; returns at the IDLE cycle after done.
   // With noisy set, start/x/y toggle randomly while the unit is busy.
   task automatic run_op(input logic [7:0] yy, input logic [7:0] xx, input bit noisy,
                         output logic [15:0] zz, output logic ee, output int lat);
      y = yy;
      x = xx;
      start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      start = 1'b0;
      while (!done && lat < 100) begin
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            y = 8'($urandom);
            x = 8'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      zz = z;
      ee = err;
      @(posedge clk); #1;
   endtask

   logic [15:0] gz, mz;
   logic        ge, me;
   int          lat, ndone, dbl, cyc;
   bit          prev;
   logic [7:0]  ry, rx;
   real         e_abs, e_max, e_sum;
   int          e_cnt;

   initial begin
      tv[0] = '{"quot_32_64",     8'd32,  8'd64,  16'd129,   1'b0, MAX_IT + 2};
      tv[1] = '{"quot_m128_m128", 8'h80,  8'h80,  16'd255,   1'b0, MAX_IT + 2};
      tv[2] = '{"quot_0_5",       8'd0,   8'd5,   16'd1,     1'b0, MAX_IT + 2};
      tv[3] = '{"quot_m64_64",    8'hC0,  8'd64,  16'hFF01,  1'b0, MAX_IT + 2};
      tv[4] = '{"err_5_x0",       8'd5,   8'd0,   16'h7FFF,  1'b1, 2};
      tv[5] = '{"err_100_m50",    8'd100, 8'hCE,  16'h8000,  1'b1, 2};
      tv[6] = '{"err_m128_127",   8'h80,  8'd127, 16'h8000,  1'b1, 2};
      tv[7] = '{"err_m3_x0",      8'hFD,  8'd0,   16'h8000,  1'b1, 2};

      rst_n = 1'b1;
      start = 1'b0;
      y = '0;
      x = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_z", int'(z), 0);
      check("reset_done", int'(done), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_err", int'(err), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) begin
         run_op(tv[k].y, tv[k].x, 1'b0, gz, ge, lat);
         check({tv[k].name, "_z"}, int'(gz), int'(tv[k].z));
         check({tv[k].name, "_err"}, int'(ge), int'(tv[k].e));
         check({tv[k].name, "_lat"}, lat, tv[k].lat);
         check({tv[k].name, "_hold"}, int'(z), int'(tv[k].z));
         check({tv[k].name, "_pulse"}, int'(done), 0);
      end

      // Random operations; every other one toggles start/x/y while busy
      e_max = 0.0;
      e_sum = 0.0;
      e_cnt = 0;
      for (int k = 0; k < 300; k++) begin
         ry = 8'($urandom);
         rx = 8'($urandom);
         if (k % 3 != 0 && rx != 0) begin
            // bias toward in-domain operands
            if ($signed(ry) > $signed(rx) && !rx[7]) ry = ry % rx;
         end
         model(ry, rx, mz, me);
         run_op(ry, rx, 1'(k % 2), gz, ge, lat);
         check("rand_z", int'(gz), int'(mz));
         check("rand_err", int'(ge), int'(me));
         check("rand_lat", lat, me ? 2 : MAX_IT + 2);
         if (!me) begin
            e_abs = $itor($signed(gz)) - 256.0 * $itor($signed(ry)) / $itor($signed(rx));
            if (e_abs < 0.0) e_abs = -e_abs;
            e_sum += e_abs;
            e_cnt++;
            if (e_abs > e_max) e_max = e_abs;
         end
      end
      if (e_cnt > 0)
         $display("quotient error vs ideal: mean %f max %f LSB over %0d ops",
                  e_sum / e_cnt, e_max, e_cnt);

      // start held high for 40 cycles: two results complete inside the window
      y = 8'd32;
      x = 8'd64;
      start = 1'b1;
      ndone = 0;
      dbl = 0;
      prev = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) ndone++;
         if (done && prev) dbl++;
         prev = done;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("hold_start_results", ndone, 2);
      check("hold_start_single_pulse", dbl, 0);
      cyc = 0;
      while (!done && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("hold_start_drain_done", int'(done), 1);
      check("hold_start_z", int'(z), 129);
      @(posedge clk); #1;

      // Reset in cycle 7 of an operation aborts without done
      y = 8'd16;
      x = 8'd48;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c < 7; c++) begin
         @(posedge clk); #1;
      end
      check("pre_reset_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("midreset_z", int'(z), 0);
      check("midreset_done", int'(done), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_err", int'(err), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      model(8'hD0, 8'd70, mz, me);
      run_op(8'hD0, 8'd70, 1'b0, gz, ge, lat);
      check("post_reset_z", int'(gz), int'(mz));
      check("post_reset_err", int'(ge), int'(me));
      check("post_reset_lat", lat, MAX_IT + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
